// File: rtl/avalon_queue_bank_pkg.sv
// Shared address map constants and control-word field helpers for the queue bank.
package avalon_queue_bank_pkg;

    localparam int CTRL_ADDR    = 0;
    localparam int CH_BASE_ADDR = 1;

    // The valid-vector status register sits right after the last channel address.
    function automatic int status_valid_offset(input int num_ch);
        return num_ch + 1;
    endfunction

    // Control word bit that flushes channel k.
    function automatic int ctrl_flush_bit(input int k);
        return k;
    endfunction

    // Control word bit that clears the sticky overflow flag of channel k.
    function automatic int ctrl_ovf_clr_bit(input int num_ch, input int k);
        return num_ch + k;
    endfunction

endpackage

// File: rtl/avalon_queue_bank_fwft.sv
// One show-ahead queue: head entry is visible on head_data whenever valid is high.
// A push into a full queue is only accepted when a pop frees a slot in the same cycle;
// otherwise it is dropped and reported on the dropped strobe.
module queue_fwft #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              valid,
    output logic              dropped
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              pop_eff;
    logic              push_eff;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign valid     = (count_q != '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr];
    assign pop_eff   = pop && valid;
    assign push_eff  = push && (!full || pop_eff);
    // A flushed push is discarded silently, so it never counts as an overflow.
    assign dropped   = push && full && !pop_eff && !flush;

    // Pointer and occupancy update; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_eff && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/avalon_queue_bank.sv
// Avalon-MM front end for NUM_CH show-ahead ingress queues: address decode,
// sticky overflow flags and the registered readdata path.
module avalon_queue_bank
    import avalon_queue_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        writedata,
    output logic [DATA_W-1:0]        readdata,
    output logic [NUM_CH-1:0]        deq_valid,
    input  logic [NUM_CH-1:0]        deq_ready,
    output logic [NUM_CH*DATA_W-1:0] deq_data,
    output logic [NUM_CH-1:0]        full
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_hit;
    logic              ctrl_wr;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] flush;
    logic [NUM_CH-1:0] ovf_clr;
    logic [NUM_CH-1:0] dropped;
    logic [NUM_CH-1:0] overflow;
    logic [CNT_W-1:0]  occ [NUM_CH];
    logic [DATA_W-1:0] rd_mux;

    assign wr_hit  = chipselect && write;
    assign ctrl_wr = wr_hit && (address == ADDR_W'(CTRL_ADDR));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign push[k]    = wr_hit && (address == ADDR_W'(CH_BASE_ADDR + k));
        assign flush[k]   = ctrl_wr && writedata[ctrl_flush_bit(k)];
        assign ovf_clr[k] = ctrl_wr && writedata[ctrl_ovf_clr_bit(NUM_CH, k)];

        queue_fwft #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_queue (
            .clk       (clk),
            .reset     (reset),
            .push      (push[k]),
            .pop       (deq_ready[k]),
            .flush     (flush[k]),
            .push_data (writedata),
            .head_data (deq_data[k*DATA_W +: DATA_W]),
            .count     (occ[k]),
            .full      (full[k]),
            .valid     (deq_valid[k]),
            .dropped   (dropped[k])
        );
    end

    // Sticky overflow flags; a new drop beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= '0;
        end else begin
            overflow <= (overflow & ~ovf_clr) | dropped;
        end
    end

    // Read mux over pre-edge state; unmapped addresses read as zero.
    always_comb begin
        rd_mux = '0;
        if (address == ADDR_W'(CTRL_ADDR)) begin
            rd_mux = DATA_W'({overflow, full});
        end else if (address == ADDR_W'(status_valid_offset(NUM_CH))) begin
            rd_mux = DATA_W'(deq_valid);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (address == ADDR_W'(CH_BASE_ADDR + k)) rd_mux = DATA_W'(occ[k]);
        end
    end

    // Registered read data, held between read strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata <= '0;
        end else if (chipselect && read) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_avalon_queue_bank.sv
// Directed bench for avalon_queue_bank with a read/pop scoreboard.
module tb_avalon_queue_bank;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     chipselect;
    logic                     write;
    logic                     read;
    logic [ADDR_W-1:0]        address;
    logic [DATA_W-1:0]        writedata;
    logic [DATA_W-1:0]        readdata;
    logic [NUM_CH-1:0]        deq_valid;
    logic [NUM_CH-1:0]        deq_ready;
    logic [NUM_CH*DATA_W-1:0] deq_data;
    logic [NUM_CH-1:0]        full;

    int          errors = 0;
    int          checks = 0;
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_q [$];
    logic [7:0]  exp_pop [NUM_CH][$];

    always #5 clk = ~clk;

    avalon_queue_bank #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_data   (deq_data),
        .full       (full)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs on every falling edge: compares read returns and observed pops.
    task automatic monitor_step();
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL readdata: got 0x%0h with no expected read", readdata);
            end else begin
                check("readdata", 32'(readdata), 32'(rd_q.pop_front()));
            end
        end
        rd_pend = chipselect && read && reset;
        for (int k = 0; k < NUM_CH; k++) begin
            if (reset && deq_ready[k] && deq_valid[k]) begin
                if (exp_pop[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_ch%0d: got 0x%0h with no expected pop", k, deq_data[k*DATA_W +: DATA_W]);
                end else begin
                    check($sformatf("pop_ch%0d", k), 32'(deq_data[k*DATA_W +: DATA_W]),
                          32'(exp_pop[k].pop_front()));
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = ADDR_W'(addr);
        writedata  = data;
        cyc();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [7:0] exp);
        rd_q.push_back(exp);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = ADDR_W'(addr);
        cyc();
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic pop_n(input int ch, input int n);
        deq_ready[ch] = 1'b1;
        repeat (n) cyc();
        deq_ready[ch] = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = '0;
        writedata  = '0;
        deq_ready  = '0;

        fork
            begin
                forever begin
                    @(negedge clk);
                    monitor_step();
                end
            end
            begin
                #2;
                check("reset_readdata", 32'(readdata), 32'h0);
                check("reset_deq_valid", 32'(deq_valid), 32'h0);
                check("reset_full", 32'(full), 32'h0);
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b1;

                // Three pushes into ch0, occupancy and show-ahead head.
                wr(1, 8'h11);
                wr(1, 8'h22);
                wr(1, 8'h33);
                rd(1, 8'd3);
                rd(5, 8'h01);
                check("t1_deq_valid", 32'(deq_valid), 32'h1);
                check("t1_head_ch0", 32'(deq_data[7:0]), 32'h11);
                check("t1_full", 32'(full), 32'h0);
                exp_pop[0].push_back(8'h11);
                exp_pop[0].push_back(8'h22);
                exp_pop[0].push_back(8'h33);
                pop_n(0, 5);
                rd(1, 8'd0);

                // Fill ch1, overflow it, drain in order.
                wr(2, 8'hA0);
                wr(2, 8'hA1);
                wr(2, 8'hA2);
                wr(2, 8'hA3);
                wr(2, 8'hFF);
                check("t2_full", 32'(full), 32'h2);
                rd(0, 8'b0010_0010);
                exp_pop[1].push_back(8'hA0);
                exp_pop[1].push_back(8'hA1);
                exp_pop[1].push_back(8'hA2);
                exp_pop[1].push_back(8'hA3);
                pop_n(1, 4);
                rd(2, 8'd0);
                wr(0, 8'h20);
                rd(0, 8'h00);

                // Push into full ch2 while popping: accepted, no overflow.
                wr(3, 8'h40);
                wr(3, 8'h41);
                wr(3, 8'h42);
                wr(3, 8'h43);
                exp_pop[2].push_back(8'h40);
                deq_ready[2] = 1'b1;
                wr(3, 8'h55);
                deq_ready[2] = 1'b0;
                rd(3, 8'd4);
                rd(0, 8'b0000_0100);
                exp_pop[2].push_back(8'h41);
                exp_pop[2].push_back(8'h42);
                exp_pop[2].push_back(8'h43);
                exp_pop[2].push_back(8'h55);
                pop_n(2, 4);

                // Flush ch3 with a same-cycle pop.
                wr(4, 8'h61);
                wr(4, 8'h62);
                exp_pop[3].push_back(8'h61);
                deq_ready[3] = 1'b1;
                wr(0, 8'h08);
                deq_ready[3] = 1'b0;
                check("t4_deq_valid", 32'(deq_valid), 32'h0);
                rd(4, 8'd0);
                rd(5, 8'h00);

                // Overflow ch0 (pointers wrap), clear flag, contents intact.
                wr(1, 8'h01);
                wr(1, 8'h02);
                wr(1, 8'h03);
                wr(1, 8'h04);
                wr(1, 8'h05);
                rd(0, 8'b0001_0001);
                wr(0, 8'h10);
                rd(0, 8'b0000_0001);
                wr(7, 8'hEE);
                rd(6, 8'h00);
                rd(1, 8'd4);
                exp_pop[0].push_back(8'h01);
                exp_pop[0].push_back(8'h02);
                exp_pop[0].push_back(8'h03);
                exp_pop[0].push_back(8'h04);
                pop_n(0, 4);
                rd(1, 8'd0);

                // Asynchronous reset in the middle of a write burst.
                wr(2, 8'hB0);
                wr(2, 8'hB1);
                wr(2, 8'hB2);
                wr(2, 8'hB3);
                rd(5, 8'h02);
                cyc();
                chipselect = 1'b1;
                write      = 1'b1;
                address    = ADDR_W'(2);
                writedata  = 8'hBF;
                #2;
                reset = 1'b0;
                #1;
                check("areset_readdata", 32'(readdata), 32'h0);
                check("areset_deq_valid", 32'(deq_valid), 32'h0);
                check("areset_full", 32'(full), 32'h0);
                chipselect = 1'b0;
                write      = 1'b0;
                cyc();
                reset = 1'b1;
                rd(1, 8'd0);
                rd(2, 8'd0);
                rd(0, 8'h00);
                repeat (3) cyc();

                check("rd_q_drained", 32'(rd_q.size()), 32'd0);
                for (int k = 0; k < NUM_CH; k++) begin
                    check($sformatf("pop_q%0d_drained", k), 32'(exp_pop[k].size()), 32'd0);
                end
            end
            begin
                #50000;
                checks++;
                errors++;
                $display("FAIL timeout: stimulus did not complete in 50000 time units");
            end
        join_any
        disable fork;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
